// File: rtl/apb_i2c_regfile_pkg.sv
// Register map, status/command/irq bit positions and access-FSM states for the I2C APB register file.
// Also holds the access-legality rule shared by the decode logic.
package apb_i2c_pkg;

   localparam logic [2:0] IDX_RSVD     = 3'd0;
   localparam logic [2:0] IDX_PRESCALE = 3'd1;
   localparam logic [2:0] IDX_ADDRESS  = 3'd2;
   localparam logic [2:0] IDX_STATUS   = 3'd3;
   localparam logic [2:0] IDX_TXDATA   = 3'd4;
   localparam logic [2:0] IDX_RXDATA   = 3'd5;
   localparam logic [2:0] IDX_COMMAND  = 3'd6;
   localparam logic [2:0] IDX_IRQ      = 3'd7;

   localparam int STS_TX_FULL  = 7;
   localparam int STS_TX_EMPTY = 6;
   localparam int STS_RX_FULL  = 5;
   localparam int STS_RX_EMPTY = 4;
   localparam int STS_BUSY     = 3;

   localparam int CMD_EN    = 7;
   localparam int CMD_START = 6;
   localparam int CMD_STOP  = 5;
   localparam int CMD_RW    = 4;
   localparam logic [7:0] CMD_MASK = 8'hF0;

   localparam int IRQ_DONE   = 0;
   localparam int IRQ_NACK   = 1;
   localparam int IRQ_ARB    = 2;
   localparam int IRQ_IE_LSB = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } apb_state_e;

   function automatic logic access_err(input logic [2:0] idx, input logic wr, input logic wr_start,
                                       input logic tx_full, input logic rx_empty, input logic busy);
      logic e;
      e = 1'b0;
      case (idx)
         IDX_RSVD:    e = 1'b1;
         IDX_STATUS:  e = wr;
         IDX_TXDATA:  e = wr ? tx_full : 1'b1;
         IDX_RXDATA:  e = wr ? 1'b1 : rx_empty;
         IDX_COMMAND: e = wr & wr_start & busy;
         default:     e = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/apb_i2c_regfile_if.sv
// APB3 bus bundle between the interconnect (master) and the I2C register file (slave).
interface apb_i2c_regfile_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_i2c_regfile_wait_ctrl.sv
// APB access FSM: PREADY rises WAIT_STATES cycles into ACCESS; commit_o marks the completing cycle.
// Dropping PSELx before PREADY abandons the transfer without a commit.
module apb_wait_ctrl
   import apb_i2c_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic psel_i,
   input  logic penable_i,
   output logic pready_o,
   output logic commit_o
);
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   apb_state_e state_q;
   logic [2:0] cnt_q;
   logic       pready_q;

   // PREADY is registered, so it is precomputed one edge ahead of the cycle it applies to.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pready_q <= 1'b0;
      end else if (!psel_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pready_q <= 1'b0;
      end else if (!penable_i) begin
         state_q  <= S_SETUP;
         cnt_q    <= '0;
         pready_q <= (WS == 3'd0);
      end else if (state_q == S_IDLE || pready_q) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= S_ACCESS;
         cnt_q    <= cnt_q + 3'd1;
         pready_q <= ((cnt_q + 3'd1) == WS);
      end
   end

   assign pready_o = pready_q;
   assign commit_o = pready_q & psel_i & penable_i;

endmodule

// File: rtl/apb_i2c_regfile.sv
// APB3 register file for the I2C master: config registers, TX/RX FIFO strobes, self-clearing commands, sticky IRQ.
// Side effects commit on the PREADY edge; illegal accesses complete with PSLVERR and no effect.
module apb_i2c_regfile
   import apb_i2c_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int WAIT_STATES  = 0,
   parameter int PRESCALE_RST = 0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_i2c_regfile_if.slave  apb,
   input  logic [DATA_W-1:0] status_reg,
   input  logic [DATA_W-1:0] receive_reg,
   output logic [DATA_W-1:0] transmit_reg,
   output logic              tx_push,
   output logic              rx_pop,
   output logic [DATA_W-1:0] prescale_reg,
   output logic [DATA_W-1:0] address_reg,
   output logic [DATA_W-1:0] command_reg,
   input  logic              evt_done,
   input  logic              evt_nack,
   input  logic              evt_arb,
   output logic              irq
);
   logic [2:0] idx;
   logic [7:0] wdat8, sts8, rdata8;
   logic       commit, pready, err, wr_ok, rd_ok;

   logic [7:0] prescale_q, prescale_d;
   logic [7:0] address_q, address_d;
   logic [7:0] transmit_q, transmit_d;
   logic [7:0] cmd_q, cmd_d;
   logic       tx_push_q, tx_push_d;
   logic       rx_pop_q, rx_pop_d;
   logic [2:0] ie_q, ie_d;
   logic [2:0] is_q, is_d, is_clr;
   logic       irq_q, irq_d;
   logic       unused_ok;

   apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .psel_i    (apb.PSELx),
      .penable_i (apb.PENABLE),
      .pready_o  (pready),
      .commit_o  (commit)
   );

   assign idx   = apb.PADDR[ADDR_W-1 -: 3];
   assign wdat8 = apb.PWDATA[7:0];
   assign sts8  = status_reg[7:0];
   assign err   = access_err(idx, apb.PWRITE, wdat8[CMD_START],
                             sts8[STS_TX_FULL], sts8[STS_RX_EMPTY], sts8[STS_BUSY]);
   assign wr_ok = commit & apb.PWRITE & ~err;
   assign rd_ok = commit & ~apb.PWRITE & ~err;

   always_comb begin
      prescale_d = prescale_q;
      address_d  = address_q;
      transmit_d = transmit_q;
      cmd_d      = cmd_q;
      tx_push_d  = 1'b0;
      rx_pop_d   = 1'b0;
      ie_d       = ie_q;
      is_clr     = '0;
      cmd_d[CMD_START] = 1'b0;
      cmd_d[CMD_STOP]  = 1'b0;
      if (wr_ok) begin
         case (idx)
            IDX_PRESCALE: prescale_d = wdat8;
            IDX_ADDRESS:  address_d  = wdat8;
            IDX_TXDATA: begin
               transmit_d = wdat8;
               tx_push_d  = 1'b1;
            end
            IDX_COMMAND:  cmd_d = wdat8 & CMD_MASK;
            IDX_IRQ: begin
               ie_d   = wdat8[IRQ_IE_LSB +: 3];
               is_clr = wdat8[2:0];
            end
            default: ;
         endcase
      end
      if (rd_ok && idx == IDX_RXDATA) rx_pop_d = 1'b1;
      // An event arriving on the clearing edge must not be lost.
      is_d  = (is_q & ~is_clr) | {evt_arb, evt_nack, evt_done};
      irq_d = |(ie_q & is_q);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         prescale_q <= 8'(PRESCALE_RST);
         address_q  <= '0;
         transmit_q <= '0;
         cmd_q      <= '0;
         tx_push_q  <= 1'b0;
         rx_pop_q   <= 1'b0;
         ie_q       <= '0;
         is_q       <= '0;
         irq_q      <= 1'b0;
      end else begin
         prescale_q <= prescale_d;
         address_q  <= address_d;
         transmit_q <= transmit_d;
         cmd_q      <= cmd_d;
         tx_push_q  <= tx_push_d;
         rx_pop_q   <= rx_pop_d;
         ie_q       <= ie_d;
         is_q       <= is_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      rdata8 = '0;
      case (idx)
         IDX_PRESCALE: rdata8 = prescale_q;
         IDX_ADDRESS:  rdata8 = address_q;
         IDX_STATUS:   rdata8 = sts8;
         IDX_RXDATA:   rdata8 = receive_reg[7:0];
         IDX_COMMAND:  rdata8 = cmd_q;
         IDX_IRQ:      rdata8 = {1'b0, ie_q, 1'b0, is_q};
         default:      rdata8 = '0;
      endcase
   end

   assign apb.PRDATA  = rd_ok ? DATA_W'(rdata8) : '0;
   assign apb.PREADY  = pready;
   assign apb.PSLVERR = commit & err;

   assign transmit_reg = DATA_W'(transmit_q);
   assign prescale_reg = DATA_W'(prescale_q);
   assign address_reg  = DATA_W'(address_q);
   assign command_reg  = DATA_W'(cmd_q);
   assign tx_push      = tx_push_q;
   assign rx_pop       = rx_pop_q;
   assign irq          = irq_q;

   assign unused_ok = ^{status_reg, receive_reg, apb.PWDATA, apb.PADDR};

endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Directed bench for apb_i2c_regfile with two wait states and a 16-bit data path.
module tb_apb_i2c_regfile;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int WS = 2;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic [DW-1:0] status_reg, receive_reg;
   logic [DW-1:0] transmit_reg, prescale_reg, address_reg, command_reg;
   logic          tx_push, rx_pop, irq;
   logic          evt_done, evt_nack, evt_arb;

   apb_i2c_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) apb ();

   apb_i2c_regfile #(
      .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .PRESCALE_RST(8'h11)
   ) dut (
      .PCLK         (PCLK),
      .PRESET       (PRESET),
      .apb          (apb),
      .status_reg   (status_reg),
      .receive_reg  (receive_reg),
      .transmit_reg (transmit_reg),
      .tx_push      (tx_push),
      .rx_pop       (rx_pop),
      .prescale_reg (prescale_reg),
      .address_reg  (address_reg),
      .command_reg  (command_reg),
      .evt_done     (evt_done),
      .evt_nack     (evt_nack),
      .evt_arb      (evt_arb),
      .irq          (irq)
   );

   always #5 PCLK = ~PCLK;

   logic [31:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] want;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s: observed=%0h but no expected value queued", tag, obs);
      end else begin
         want = exp_q.pop_front();
         assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
         end
      end
   endtask

   task automatic expect_v(input string tag, input logic [31:0] obs, input logic [31:0] want);
      exp_q.push_back(want);
      chk(tag, obs);
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // Returns #1 after the completion edge; wait count saturates at 20 if PREADY never rises.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output logic err, output int waits);
      apb.PSELx   = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = wr;
      apb.PADDR   = addr;
      apb.PWDATA  = wdata;
      step();
      apb.PENABLE = 1'b1;
      waits = 0;
      while (apb.PREADY !== 1'b1 && waits < 20) begin
         step();
         waits++;
      end
      rdata = apb.PRDATA;
      err   = apb.PSLVERR;
      step();
      apb.PSELx   = 1'b0;
      apb.PENABLE = 1'b0;
   endtask

   task automatic apb_wr(input string tag, input logic [7:0] addr, input logic [15:0] d,
                         input logic exp_err);
      logic [15:0] r;
      logic        e;
      int          w;
      exp_q.push_back(32'(WS));
      exp_q.push_back({31'd0, exp_err});
      xfer(1'b1, addr, d, r, e, w);
      chk({tag, ".wait"}, 32'(w));
      chk({tag, ".err"}, {31'd0, e});
   endtask

   task automatic apb_rd(input string tag, input logic [7:0] addr, input logic [15:0] exp_d,
                         input logic exp_err);
      logic [15:0] r;
      logic        e;
      int          w;
      exp_q.push_back(32'(WS));
      exp_q.push_back({16'd0, exp_d});
      exp_q.push_back({31'd0, exp_err});
      xfer(1'b0, addr, 16'h0000, r, e, w);
      chk({tag, ".wait"}, 32'(w));
      chk({tag, ".data"}, {16'd0, r});
      chk({tag, ".err"}, {31'd0, e});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      PRESET      = 1'b1;
      apb.PSELx   = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = '0;
      apb.PWDATA  = '0;
      status_reg  = 16'h0050;
      receive_reg = 16'h0000;
      evt_done    = 1'b0;
      evt_nack    = 1'b0;
      evt_arb     = 1'b0;
      repeat (3) step();

      expect_v("rst.pready",   apb.PREADY,   0);
      expect_v("rst.pslverr",  apb.PSLVERR,  0);
      expect_v("rst.prdata",   apb.PRDATA,   0);
      expect_v("rst.tx_push",  tx_push,      0);
      expect_v("rst.rx_pop",   rx_pop,       0);
      expect_v("rst.prescale", prescale_reg, 32'h11);
      expect_v("rst.address",  address_reg,  0);
      expect_v("rst.command",  command_reg,  0);
      expect_v("rst.transmit", transmit_reg, 0);
      expect_v("rst.irq",      irq,          0);
      PRESET = 1'b0;
      step();

      // Config registers; upper PWDATA bits must be dropped
      apb_wr("prescale.wr", 8'h20, 16'hFF2A, 1'b0);
      expect_v("prescale.val", prescale_reg, 32'h2A);
      apb_rd("prescale.rd", 8'h20, 16'h002A, 1'b0);
      apb_wr("address.wr", 8'h40, 16'h005A, 1'b0);
      apb_rd("address.rd", 8'h40, 16'h005A, 1'b0);
      status_reg = 16'hFF48;
      apb_rd("status.rd", 8'h60, 16'h0048, 1'b0);
      apb_wr("status.wr", 8'h60, 16'h0001, 1'b1);
      apb_rd("rsvd.rd", 8'h00, 16'h0000, 1'b1);

      // TX FIFO push
      status_reg = 16'h0040;
      apb_wr("tx.wr", 8'h80, 16'h0055, 1'b0);
      expect_v("tx.push1", tx_push, 1);
      expect_v("tx.data",  transmit_reg, 32'h55);
      step();
      expect_v("tx.push0", tx_push, 0);
      status_reg = 16'h0080;
      apb_wr("tx.full", 8'h80, 16'h0066, 1'b1);
      expect_v("tx.full.push", tx_push, 0);
      expect_v("tx.full.data", transmit_reg, 32'h55);
      apb_rd("tx.rd", 8'h80, 16'h0000, 1'b1);

      // RX FIFO pop
      receive_reg = 16'h00A3;
      status_reg  = 16'h0000;
      apb_rd("rx.rd", 8'hA0, 16'h00A3, 1'b0);
      expect_v("rx.pop1", rx_pop, 1);
      step();
      expect_v("rx.pop0", rx_pop, 0);
      status_reg = 16'h0010;
      apb_rd("rx.empty", 8'hA0, 16'h0000, 1'b1);
      expect_v("rx.empty.pop", rx_pop, 0);
      apb_wr("rx.wr", 8'hA0, 16'h0001, 1'b1);

      // COMMAND self-clearing bits and BUSY guard
      status_reg = 16'h0000;
      apb_wr("cmd.wr", 8'hC0, 16'h00C0, 1'b0);
      expect_v("cmd.start", command_reg, 32'hC0);
      step();
      expect_v("cmd.held", command_reg, 32'h80);
      status_reg = 16'h0008;
      apb_wr("cmd.busy", 8'hC0, 16'h00D0, 1'b1);
      expect_v("cmd.busy.val", command_reg, 32'h80);
      apb_wr("cmd.rw", 8'hC0, 16'h009F, 1'b0);
      expect_v("cmd.rw.val", command_reg, 32'h90);
      apb_rd("cmd.rd", 8'hC0, 16'h0090, 1'b0);

      // IRQ latency, set-beats-clear, W1C
      apb_wr("irq.ie", 8'hE0, 16'h0030, 1'b0);
      evt_nack = 1'b1;
      step();
      evt_nack = 1'b0;
      expect_v("irq.lat1", irq, 0);
      step();
      expect_v("irq.lat2", irq, 1);
      apb_rd("irq.rd", 8'hE0, 16'h0032, 1'b0);
      evt_nack = 1'b1;
      apb_wr("irq.race", 8'hE0, 16'h0032, 1'b0);
      evt_nack = 1'b0;
      apb_rd("irq.rd2", 8'hE0, 16'h0032, 1'b0);
      expect_v("irq.still", irq, 1);
      apb_wr("irq.w1c", 8'hE0, 16'h0032, 1'b0);
      step();
      expect_v("irq.clr", irq, 0);
      apb_rd("irq.rd3", 8'hE0, 16'h0030, 1'b0);
      evt_arb = 1'b1;
      step();
      evt_arb = 1'b0;
      step();
      expect_v("irq.masked", irq, 0);
      apb_rd("irq.rd4", 8'hE0, 16'h0034, 1'b0);
      evt_done = 1'b1;
      step();
      evt_done = 1'b0;
      step();
      expect_v("irq.done", irq, 1);

      // PSELx dropped mid-ACCESS: no commit
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
      apb.PADDR = 8'h20; apb.PWDATA = 16'h0077;
      step();
      apb.PENABLE = 1'b1;
      step();
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
      repeat (3) step();
      expect_v("abort.prescale", prescale_reg, 32'h2A);
      expect_v("abort.pready", apb.PREADY, 0);

      // Reset on the completing cycle of a TXDATA write
      status_reg = 16'h0040;
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
      apb.PADDR = 8'h80; apb.PWDATA = 16'h0099;
      step();
      apb.PENABLE = 1'b1;
      repeat (WS) step();
      expect_v("prst.ready", apb.PREADY, 1);
      PRESET = 1'b1;
      step();
      expect_v("prst.tx_push",  tx_push,      0);
      expect_v("prst.transmit", transmit_reg, 0);
      expect_v("prst.prescale", prescale_reg, 32'h11);
      expect_v("prst.address",  address_reg,  0);
      expect_v("prst.command",  command_reg,  0);
      expect_v("prst.irq",      irq,          0);
      expect_v("prst.pready",   apb.PREADY,   0);
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
      PRESET = 1'b0;
      step();
      expect_v("prst.tx_push2", tx_push, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
